// File: rtl/burst_arb_pkg.sv
// Shared types and helpers for the burst arbiter: FSM state encoding and
// owner-index width calculation.
package burst_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/burst_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr_i (wrapping) wins.
module rr_pick
    import burst_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = owner_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic found;
    int   j;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        j        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found       = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = IDX_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/burst_arbiter.sv
// Burst arbiter: grants one requester a shared resource for len+1 acked
// beats, rotating priority between bursts with no idle bubble.
module burst_arbiter
    import burst_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*LEN_W-1:0]   len_i,
    input  logic                     ack_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [owner_w(N_REQ)-1:0] owner_o,
    output logic                     busy_o,
    output logic [LEN_W-1:0]         beats_left_o,
    output logic                     done_o
);

    localparam int IDX_W = owner_w(N_REQ);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic               done_q,  done_d;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               take;
    logic [LEN_W-1:0]   len_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_len
        assign len_arr[g] = len_i[g*LEN_W +: LEN_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        beats_d = beats_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        take    = 1'b0;
        case (state_q)
            IDLE: take = pick_any;
            BURST: begin
                if (ack_i) begin
                    if (beats_q != '0) begin
                        beats_d = beats_q - 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // Re-arbitrate in the final-beat cycle so the next burst starts without a gap.
                        if (pick_any) begin
                            take = 1'b1;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                            beats_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = BURST;
            grant_d = pick_onehot;
            owner_d = pick_idx;
            beats_d = len_arr[pick_idx];
            ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            beats_q <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign grant_o      = grant_q;
    assign owner_o      = owner_q;
    assign busy_o       = (state_q == BURST);
    assign beats_left_o = beats_q;
    assign done_o       = done_q;

endmodule

// File: doc/burst_arbiter.md
BURST_ARBITER -- requirements
Module: burst_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 Parameter LEN_W, default 4, width of per-requester burst length field (beats minus one).
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 arst  input  1  reset, asynchronous, active-high.
REQ-005 req_i  input  N_REQ  per-requester burst request, level.
REQ-006 len_i  input  N_REQ*LEN_W  per-requester burst length minus one; requester i at bits [i*LEN_W +: LEN_W].
REQ-007 ack_i  input  1  shared resource accepted one beat from the current owner this cycle.
REQ-008 grant_o  output  N_REQ  one-hot grant, registered.
REQ-009 owner_o  output  max(1,$clog2(N_REQ))  index of granted requester, registered.
REQ-010 busy_o  output  1  burst in progress, registered.
REQ-011 beats_left_o  output  LEN_W  beats remaining after the current one, registered.
REQ-012 done_o  output  1  one-cycle pulse, registered, cycle after the final beat is acked.

Function
REQ-013 The FSM SHALL have two states, IDLE and BURST.
REQ-014 In IDLE, grant_o=0, busy_o=0, and ack_i is ignored.
REQ-015 In IDLE with any req_i set, the block SHALL pick a winner by rotating priority starting at pointer ptr, then enter BURST next cycle with grant_o one-hot at the winner, owner_o=winner, and beats_left_o=len_i[winner] latched.
REQ-016 Arbitration latency SHALL be one cycle: request sampled at edge k yields grant visible after edge k+1.
REQ-017 On every grant, ptr SHALL update to (winner+1) mod N_REQ.
REQ-018 In BURST, ack_i with beats_left_o>0 SHALL decrement beats_left_o by one.
REQ-019 In BURST, ack_i with beats_left_o==0 ends the burst, and done_o SHALL be 1 in the next cycle only.
REQ-020 At burst end with any req_i set (including the finishing owner's), the block SHALL arbitrate in the same cycle using the updated ptr and stay in BURST with the new grant next cycle, with no idle bubble.
REQ-021 At burst end with no req_i set, the block SHALL return to IDLE, with grant_o=0 next cycle.
REQ-022 A grant SHALL be held for exactly len+1 acked beats regardless of req_i deasserting mid-burst.
REQ-023 Changes to len_i after the grant SHALL be ignored.
REQ-024 A sole requester SHALL win consecutive bursts back-to-back.
REQ-025 len=0 SHALL be a one-beat burst.
REQ-026 len=all-ones SHALL be a 2^LEN_W-beat burst with no wrap of the counter.
REQ-027 grant_o SHALL never have more than one bit set.
REQ-028 grant_o SHALL change only at burst end.

Reset
REQ-029 On arst assertion, immediately: state=IDLE, grant_o=0, owner_o=0, busy_o=0, beats_left_o=0, done_o=0, ptr=0.
REQ-030 On reset mid-burst, the burst SHALL be abandoned with no done_o pulse.
REQ-031 The first arbitration after reset SHALL occur on the first rising edge with arst low.

Structure
REQ-032 Package burst_arb_pkg SHALL hold the state enum (IDLE, BURST) and a function giving the owner index width.
REQ-033 Sub-module rr_pick SHALL hold the combinational rotating-priority picker: inputs req and ptr; outputs one-hot, index and any.
REQ-034 burst_arbiter SHALL instantiate rr_pick once.

Verification (N_REQ=4, LEN_W=4)
REQ-035 Scenario 1: reset; req_i=0010, len1=2, ack_i held 1 -> grant_o=0010 one cycle after req; three acks; done_o one cycle later; then grant_o=0.
REQ-036 Scenario 2: req_i=1111 held, all len=0, ack_i=1 -> grants rotate 0001,0010,0100,1000,0001, each one cycle, no gaps.
REQ-037 Scenario 3: owner 0, len0=3; req0 dropped after first ack -> grant held for 4 acks total; done_o pulses once.
REQ-038 Scenario 4: ack_i toggling 1,0,1,0 during len=15 burst -> beats_left_o 15..0 over exactly 16 acks; no counter wrap.
REQ-039 Scenario 5: arst asserted while beats_left_o=5 -> all outputs 0 asynchronously, no done_o; after release, req_i=0100 -> grant_o=0100 with ptr restarted at 0.
REQ-040 Scenario 6: only req2 held with len=1, ack_i=1 -> grant_o=0100 continuously across consecutive bursts; done_o every 2nd cycle.
